// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO multiply unit: op encodings (also visible to the
// main controller as `defines), operand width and the signed-magnitude helper.
`ifndef HILO_UNIT_OPS_DEFINED
`define HILO_UNIT_OPS_DEFINED
`define OP_NOP   3'd0
`define OP_MULT  3'd1
`define OP_MULTU 3'd2
`define OP_MTHI  3'd3
`define OP_MTLO  3'd4
`endif

package hilo_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_NOP   = `OP_NOP,
        OP_MULT  = `OP_MULT,
        OP_MULTU = `OP_MULTU,
        OP_MTHI  = `OP_MTHI,
        OP_MTLO  = `OP_MTLO
    } op_e;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                  input logic is_signed);
        magnitude = (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/hilo_unit_multiplier.sv
// Unsigned 32x32 shift-add multiplier: one partial product per cycle, ready after
// 32 iterations. Internal state is deliberately unreset; start reinitialises it.
module multiplier (
    input  logic        clk,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [63:0] Product,
    output logic        ready
);

    logic [63:0] mcand_reg;
    logic [31:0] mplier_reg;
    logic [63:0] acc_reg;
    logic [5:0]  count_reg;
    logic        ready_reg;

    always_ff @(posedge clk) begin
        if (start) begin
            mcand_reg  <= {32'd0, A};
            mplier_reg <= B;
            acc_reg    <= 64'd0;
            count_reg  <= 6'd0;
            ready_reg  <= 1'b0;
        end else if (!count_reg[5]) begin
            if (mplier_reg[0]) begin
                acc_reg <= acc_reg + mcand_reg;
            end
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg + 6'd1;
            ready_reg  <= (count_reg == 6'd31);
        end
    end

    assign Product = acc_reg;
    assign ready   = ready_reg;

endmodule

// File: rtl/hilo_unit.sv
// MIPS HI/LO unit: accepts MULT/MULTU/MTHI/MTLO in IDLE, runs the unsigned
// multiplier on operand magnitudes and sign-corrects the 64-bit result into HI/LO.
module hilo_unit
    import hilo_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_e;

    state_e            state_reg, state_next;
    logic [XLEN-1:0]   mag_a_reg, mag_b_reg;
    logic              neg_reg;
    logic [XLEN-1:0]   hi_reg, lo_reg;
    logic              done_reg;
    logic              mul_start;
    logic              mul_ready;
    logic [2*XLEN-1:0] product;
    logic [2*XLEN-1:0] result;
    logic              is_mul;

    assign is_mul = (op == `OP_MULT) || (op == `OP_MULTU);
    assign result = neg_reg ? (~product + 64'd1) : product;

    always_comb begin
        state_next = state_reg;
        mul_start  = 1'b0;
        case (state_reg)
            ST_IDLE:    if (is_mul) state_next = ST_START;
            ST_START: begin
                mul_start  = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT:    if (mul_ready) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            mag_a_reg <= '0;
            mag_b_reg <= '0;
            neg_reg   <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == ST_CAPTURE);
            if (state_reg == ST_IDLE) begin
                if (is_mul) begin
                    mag_a_reg <= magnitude(a, op == `OP_MULT);
                    mag_b_reg <= magnitude(b, op == `OP_MULT);
                    neg_reg   <= (op == `OP_MULT) && (a[XLEN-1] ^ b[XLEN-1]);
                end else if (op == `OP_MTHI) begin
                    hi_reg <= a;
                end else if (op == `OP_MTLO) begin
                    lo_reg <= a;
                end
            end else if (state_reg == ST_CAPTURE) begin
                {hi_reg, lo_reg} <= result;
            end
        end
    end

    multiplier u_multiplier (
        .clk     (clk),
        .start   (mul_start),
        .A       (mag_a_reg),
        .B       (mag_b_reg),
        .Product (product),
        .ready   (mul_ready)
    );

    assign busy = (state_reg != ST_IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: table of multiply vectors plus hand-written
// sequences for reset mid-multiply, MTHI/MTLO, op-ignored-while-busy and back-to-back.
module tb_hilo_unit;
    import hilo_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    hilo_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Called at a negedge with the unit idle; returns at the negedge where busy is low.
    task automatic run_mul(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                           input logic [2:0] busy_op, input logic [31:0] busy_a,
                           output int bcyc, output int dcnt);
        op = mop;
        a  = ma;
        b  = mb;
        @(posedge clk);
        bcyc = 0;
        dcnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) dcnt++;
            if (!busy) begin
                op = OP_NOP;
                break;
            end
            bcyc++;
            op = busy_op;
            a  = busy_a;
        end
        op = OP_NOP;
    endtask

    int bc, dc;

    initial begin
        vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{OP_MULT,  32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6};
        vecs[2] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3] = '{OP_MULT,  32'hFFFFFFFB, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[4] = '{OP_MULT,  32'hFFFFFFFD, 32'hFFFFFFFC, 32'h00000000, 32'h0000000C};
        vecs[5] = '{OP_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
        vecs[6] = '{OP_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
        vecs[7] = '{OP_MULTU, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};

        rst_n = 1'b0;
        op = OP_NOP;
        a = 32'd0;
        b = 32'd0;
        #12;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-multiply after preloading HI so the clear is observable
        op = OP_MTHI; a = 32'hA5A5A5A5;
        @(negedge clk);
        op = OP_MTLO; a = 32'h5A5A5A5A;
        @(negedge clk);
        op = OP_MULTU; a = 32'd7; b = 32'd9;
        @(posedge clk);
        @(negedge clk);
        op = OP_NOP;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_hi", hi, 32'd0);
        check("midreset_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_mul(OP_MULTU, 32'd3, 32'd5, OP_NOP, 32'd0, bc, dc);
        check("after_reset_lo", lo, 32'd15);
        check("after_reset_hi", hi, 32'd0);
        check("after_reset_busy_cycles", bc, 35);

        // Table of multiply vectors
        for (int i = 0; i < 8; i++) begin
            run_mul(vecs[i].op, vecs[i].a, vecs[i].b, OP_NOP, 32'd0, bc, dc);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
            check($sformatf("vec%0d_busy_cycles", i), bc, 35);
            check($sformatf("vec%0d_done_pulses", i), dc, 1);
            @(negedge clk);
            check($sformatf("vec%0d_done_low", i), {31'd0, done}, 32'd0);
        end

        // MTHI then MTLO on consecutive cycles
        op = OP_MTHI; a = 32'hDEADBEEF;
        @(posedge clk); #1;
        check("mthi_hi", hi, 32'hDEADBEEF);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        op = OP_MTLO; a = 32'h12345678;
        @(posedge clk); #1;
        check("mtlo_lo", lo, 32'h12345678);
        check("mtlo_hi_kept", hi, 32'hDEADBEEF);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        op = OP_NOP;
        check("mt_done", {31'd0, done}, 32'd0);

        // MTLO held throughout the busy window is ignored
        run_mul(OP_MULT, 32'd2, 32'd3, OP_MTLO, 32'hFFFFFFFF, bc, dc);
        check("ignored_mtlo_lo", lo, 32'd6);
        check("ignored_mtlo_hi", hi, 32'd0);
        check("ignored_mtlo_busy_cycles", bc, 35);

        // Back-to-back: second op issued on the cycle busy falls
        run_mul(OP_MULTU, 32'd2, 32'd2, OP_NOP, 32'd0, bc, dc);
        check("b2b_first_lo", lo, 32'd4);
        run_mul(OP_MULTU, 32'd10, 32'd10, OP_NOP, 32'd0, bc, dc);
        check("b2b_second_lo", lo, 32'd100);
        check("b2b_second_busy_cycles", bc, 35);
        check("b2b_second_done_pulses", dc, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
